// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC, fetch buffer entry type and fetch FSM states.
// Ports: none (package). Optional feature macro used by fetch_unit: FETCH_PERF_CNT_EN.
package fetch_pkg;
    localparam int ADDR_W = 8;
    localparam int INSTR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
    typedef enum logic {RUN, HALTED} state_e;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry FIFO of fetch_entry_t with push/pop/flush; head is zero when empty.
// Ports: clk, rst_n (async active-low), i_data/i_push (write), i_pop (consume head),
//        i_flush (drop all entries), o_head (current head), o_count (0..2).
// The caller never pushes when full without popping and never pops when empty.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  fetch_entry_t i_data,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);
    fetch_entry_t r_e0, r_e1;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            // r_e0 is always the head; r_e1 holds the second entry when count=2
            if (i_pop)
                r_e0 <= (i_push && r_count == 2'd1) ? i_data : r_e1;
            else if (i_push && r_count == 2'd0)
                r_e0 <= i_data;
            if (i_push && (i_pop ? r_count == 2'd2 : r_count == 2'd1))
                r_e1 <= i_data;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = (r_count != 2'd0) ? r_e0 : '0;
    assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; owns the PC, reads imem combinationally and buffers {pc, instr} for decode.
// Ports: clk, rst_n (async active-low); imem_addr/imem_rd (instruction memory);
//        br_taken/br_target (redirect from execute); halt (level, stops fetch);
//        dec_valid/dec_ready/dec_instr/dec_pc (decode handshake).
// Optional: define FETCH_PERF_CNT_EN to add perf_fetch_cnt[15:0], a saturating count of pushes.
module fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetch_cnt
`endif
);
    import fetch_pkg::*;

    state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]   w_count;
    logic         w_pop, w_fetch;
    fetch_entry_t w_push_entry, w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= br_taken ? br_target : w_fetch ? r_pc + 1'b1 : r_pc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = dec_valid & dec_ready;
        w_fetch     = 1'b0;
        w_state_nxt = (r_state == RUN) ? ((halt && !br_taken) ? HALTED : RUN)
                                       : (halt ? HALTED : RUN);
        // count - pop < 2: a full buffer only accepts a push when its head leaves
        w_fetch     = (r_state == RUN) && !halt && !br_taken && !(w_count == 2'd2 && !w_pop);
    end

    assign w_push_entry = '{pc: r_pc, instr: imem_rd};

    fetch_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (w_push_entry),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (br_taken),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_addr = r_pc;
    assign dec_valid = w_count != 2'd0;
    assign dec_instr = w_head.instr;
    assign dec_pc    = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_perf <= '0;
        else if (w_fetch && r_perf != 16'hFFFF)
            r_perf <= r_perf + 16'd1;
    end
    assign perf_fetch_cnt = r_perf;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rd;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic        halt = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [15:0] dec_instr;
    logic [7:0]  dec_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
`endif

    logic [15:0] mem [256];
    assign imem_rd = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halt      (halt),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_instr (dec_instr),
        .dec_pc    (dec_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       ready;
        logic       br;
        logic [7:0] tgt;
        logic       halt;
        logic       ev;
        logic [7:0] epc;
        logic [7:0] eaddr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vt [36];

    function automatic vec_t mk(input logic rst, input logic ready, input logic br, input logic [7:0] tgt,
                                input logic hlt, input logic ev, input logic [7:0] epc, input logic [7:0] eaddr);
        vec_t v;
        v.rst = rst; v.ready = ready; v.br = br; v.tgt = tgt; v.halt = hlt;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [7:0] epc, input logic [7:0] eaddr);
        check({tag, " valid"}, {31'b0, dec_valid}, {31'b0, ev});
        check({tag, " pc"}, {24'b0, dec_pc}, ev ? {24'b0, epc} : 32'h0);
        check({tag, " instr"}, {16'b0, dec_instr}, ev ? {16'b0, mem[epc]} : 32'h0);
        check({tag, " addr"}, {24'b0, imem_addr}, {24'b0, eaddr});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, 8'(i)};
        mem[0] = 16'h4C05;
        mem[2] = 16'hFC00;
        mem[3] = 16'hFE01;
        mem[6] = 16'h06D0;

        //          rst rdy br  tgt    hlt ev  epc    addr
        vt[0]  = mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        vt[1]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        vt[2]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01);
        vt[3]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h01, 8'h02);
        vt[4]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h02, 8'h03);
        vt[5]  = mk(0, 1, 1, 8'h06, 0, 1, 8'h03, 8'h04);
        vt[6]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h06);
        vt[7]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h06, 8'h07);
        vt[8]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h07, 8'h08);
        vt[9]  = mk(0, 0, 0, 8'h00, 0, 1, 8'h08, 8'h09);
        vt[10] = mk(0, 0, 0, 8'h00, 0, 1, 8'h08, 8'h0A);
        vt[11] = mk(0, 0, 0, 8'h00, 0, 1, 8'h08, 8'h0A);
        vt[12] = mk(0, 1, 0, 8'h00, 0, 1, 8'h08, 8'h0A);
        vt[13] = mk(0, 1, 0, 8'h00, 0, 1, 8'h09, 8'h0B);
        vt[14] = mk(0, 0, 0, 8'h00, 0, 1, 8'h0A, 8'h0C);
        vt[15] = mk(0, 0, 1, 8'hFF, 0, 1, 8'h0A, 8'h0C);
        vt[16] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'hFF);
        vt[17] = mk(0, 1, 0, 8'h00, 0, 1, 8'hFF, 8'h00);
        vt[18] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01);
        vt[19] = mk(0, 0, 0, 8'h00, 0, 1, 8'h01, 8'h02);
        vt[20] = mk(0, 0, 0, 8'h00, 1, 1, 8'h01, 8'h03);
        vt[21] = mk(0, 1, 0, 8'h00, 1, 1, 8'h01, 8'h03);
        vt[22] = mk(0, 1, 0, 8'h00, 1, 1, 8'h02, 8'h03);
        vt[23] = mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 8'h03);
        vt[24] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h03);
        vt[25] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h03);
        vt[26] = mk(0, 1, 0, 8'h00, 1, 1, 8'h03, 8'h04);
        vt[27] = mk(0, 1, 1, 8'h10, 1, 0, 8'h00, 8'h04);
        vt[28] = mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 8'h10);
        vt[29] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h10);
        vt[30] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h10);
        vt[31] = mk(0, 0, 0, 8'h00, 0, 1, 8'h10, 8'h11);
        vt[32] = mk(0, 0, 0, 8'h00, 0, 1, 8'h10, 8'h12);
        vt[33] = mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        vt[34] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        vt[35] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01);

        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            rst_n     = ~vt[i].rst;
            dec_ready = vt[i].ready;
            br_taken  = vt[i].br;
            br_target = vt[i].tgt;
            halt      = vt[i].halt;
            #1;
            check_outs($sformatf("v%0d", i), vt[i].ev, vt[i].epc, vt[i].eaddr);
        end

        // async reset landing just after a clock edge, with the buffer full
        @(negedge clk);
        dec_ready = 1'b0;
        br_taken  = 1'b0;
        halt      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_outs("full_before_rst", 1'b1, 8'h01, 8'h03);
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 8'h00, 8'h00);
`ifdef FETCH_PERF_CNT_EN
        check("perf_rst", {16'b0, perf_fetch_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_outs("after_5", 1'b1, 8'h04, 8'h05);
`ifdef FETCH_PERF_CNT_EN
        check("perf_5", {16'b0, perf_fetch_cnt}, 32'd5);
        // a flush drops entries but not the push count
        @(negedge clk);
        br_taken  = 1'b1;
        br_target = 8'h20;
        @(negedge clk);
        br_taken = 1'b0;
        #1;
        check("perf_flush", {16'b0, perf_fetch_cnt}, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 8-bit processor, sitting directly upstream of imem and downstream-feeding the decoder.
- Owns the program counter and drives imem Addr; captures imem rd (combinational, same-cycle read) into a 2-entry buffer.
- Presents {instr, pc} to decode with a valid/ready handshake; handles taken-branch redirect/flush and halt.

Parameters:
- ADDR_W, 8, PC / imem address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  address to imem Addr; equals PC register
- imem_rd  in  INSTR_W  instruction from imem rd, valid same cycle as imem_addr
- br_taken  in  1  redirect request from execute
- br_target  in  ADDR_W  redirect PC
- halt  in  1  level; suppresses fetch while high
- dec_valid  out  1  buffer head valid
- dec_ready  in  1  decoder accepts head
- dec_instr  out  INSTR_W  head instruction
- dec_pc  out  ADDR_W  address of head instruction

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, buffer count=0, state=RUN; dec_valid=0, dec_instr=0, dec_pc=0, imem_addr=RESET_PC.
- Buffer: 2-entry FIFO of {pc, instr}, count 0..2. pop = dec_valid & dec_ready. Outputs always reflect head; dec_instr/dec_pc = 0 when count=0.
- Fetch condition: state=RUN & !halt & !br_taken & (count - pop) < 2. On fetch: push {pc, imem_rd}; pc <= pc + 1, mod 2^ADDR_W (8'hFF -> 8'h00, no flag).
- Latency: instruction at address A is visible on dec_* the cycle after imem_addr=A is fetched; first dec_valid one cycle after reset release.
- Full: count=2 & !pop -> no push, pc holds, imem_addr stable. count=2 & pop -> push allowed (simultaneous push/pop, count stays 2).
- Empty: count=0 -> dec_valid=0; pop impossible.
- Branch (highest priority): br_taken -> buffer flushed (count=0), pc <= br_target, no push this cycle. A pop in the same cycle still counts as a completed transfer. dec_valid=0 the cycle after; target instruction valid the cycle after that (2-cycle redirect).
- States: RUN, HALTED. RUN->HALTED when halt=1 and br_taken=0; HALTED->RUN when halt=0. In HALTED, no fetch, pc holds, buffer drains normally. br_taken in HALTED still flushes and loads pc, state remains HALTED.
- Reset mid-operation: all state discarded immediately, outputs take reset values asynchronously.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: extra output perf_fetch_cnt[15:0]. Increments on every push, saturates at 16'hFFFF, cleared by reset, unaffected by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: ADDR_W, INSTR_W, RESET_PC defaults, typedef fetch_entry_t {pc, instr}, state enum {RUN, HALTED}.
- Sub-module fetch_skid_fifo: 2-entry FIFO of fetch_entry_t with push/pop/flush and count. fetch_unit holds PC, FSM and push/flush control.

Test Plan:
- Reset release, dec_ready=1, imem[0..3]=4C05,xxxx,FC00,FE01 -> cycle 1: dec_valid=1, dec_pc=00, dec_instr=16'h4C05; then pc 01,02,03 in consecutive cycles, one per cycle.
- dec_ready=0 from cycle 1 for 3 cycles -> count reaches 2, imem_addr holds at 8'h02. Release -> dec_pc 00,01,02 in order, no loss or duplication.
- br_taken=1, br_target=8'h06, imem[6]=16'h06D0, mid-stream -> one cycle dec_valid=0, then dec_pc=06, dec_instr=16'h06D0, followed by pc 07.
- br_target=8'hFF, dec_ready=1 -> dec_pc sequence FF, 00, 01 (wrap-around).
- halt=1 with count=2, dec_ready=1 -> two drains then dec_valid=0, imem_addr constant. halt=0 -> fetch resumes at held pc.
- rst_n asserted mid-stream with count=2 -> dec_valid=0 and imem_addr=00 immediately (before next clk edge). With FETCH_PERF_CNT_EN, perf_fetch_cnt=0.
